// File: rtl/hall_emulator.sv
// Behavioural BLDC motor / hall-sensor model: integrates speed and rotor position from the
// commutation controller's phase selects and PWM duty, and emits the 3-bit hall code.
module hall_emulator #(
  parameter int unsigned OMEGA_W     = 16,
  parameter int unsigned POS_W       = 24,
  parameter int unsigned STEP_THRESH = 24'h10000,
  parameter int unsigned OMEGA_MAX   = 16'hFFFF,
  parameter int unsigned UPD_DIV     = 1024,
  parameter int unsigned ACC_SHIFT   = 4,
  parameter int unsigned FRIC_SHIFT  = 8,
  parameter int unsigned BRAKE_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         selGrn,
  input  logic [1:0]         selYlw,
  input  logic [1:0]         selBlu,
  input  logic [10:0]        duty,
  output logic               hallGrn,
  output logic               hallYlw,
  output logic               hallBlu,
  output logic [OMEGA_W-1:0] omega,
  output logic               step,
  output logic [15:0]        rev_cnt
);

  localparam int unsigned CNT_W  = $clog2(UPD_DIV);
  localparam int unsigned WIDE_W = OMEGA_W + 12;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(UPD_DIV - 1);
  localparam logic [POS_W:0]    THRESH    = (POS_W + 1)'(STEP_THRESH);
  localparam logic [POS_W-1:0]  THRESH_LO = POS_W'(STEP_THRESH);
  localparam logic [WIDE_W-1:0] OMAX_WIDE = WIDE_W'(OMEGA_MAX);

  typedef enum logic [1:0] {
    CLS_COAST,
    CLS_MATCH,
    CLS_BRAKE
  } drive_cls_e;

  logic [2:0]         idx_q, idx_d;
  logic [2:0]         hall_q, hall_d;
  logic [OMEGA_W-1:0] omega_q, omega_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               step_q, step_d;
  logic [15:0]        rev_cnt_q, rev_cnt_d;

  drive_cls_e         drive_cls;
  logic               tick;
  logic [5:0]         sel_all;
  logic [POS_W:0]     pos_sum;
  logic [WIDE_W-1:0]  acc_sum;
  logic [WIDE_W-1:0]  brake_dec;

  // Expected {G,Y,B} select pattern for each rotor state
  function automatic logic [5:0] exp_pattern(input logic [2:0] i);
    case (i)
      3'd0:    exp_pattern = 6'b10_01_00;
      3'd1:    exp_pattern = 6'b10_00_01;
      3'd2:    exp_pattern = 6'b00_10_01;
      3'd3:    exp_pattern = 6'b01_10_00;
      3'd4:    exp_pattern = 6'b01_00_10;
      3'd5:    exp_pattern = 6'b00_01_10;
      default: exp_pattern = 6'b00_00_00;
    endcase
  endfunction

  function automatic logic [2:0] hall_code(input logic [2:0] i);
    case (i)
      3'd0:    hall_code = 3'b101;
      3'd1:    hall_code = 3'b100;
      3'd2:    hall_code = 3'b110;
      3'd3:    hall_code = 3'b010;
      3'd4:    hall_code = 3'b011;
      3'd5:    hall_code = 3'b001;
      default: hall_code = 3'b101;
    endcase
  endfunction

  always_comb begin
    sel_all    = {selGrn, selYlw, selBlu};
    drive_cls  = CLS_COAST;
    if (sel_all == 6'b11_11_11) begin
      drive_cls = CLS_BRAKE;
    end else if (sel_all == exp_pattern(idx_q)) begin
      drive_cls = CLS_MATCH;
    end

    tick       = (tick_cnt_q == CNT_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Position moves with the registered speed, so a tick's new omega lands one cycle later
    pos_sum   = {1'b0, pos_q} + (POS_W + 1)'(omega_q);
    pos_d     = pos_sum[POS_W-1:0];
    idx_d     = idx_q;
    step_d    = 1'b0;
    rev_cnt_d = rev_cnt_q;
    if (pos_sum >= THRESH) begin
      pos_d  = pos_sum[POS_W-1:0] - THRESH_LO;
      step_d = 1'b1;
      if (idx_q == 3'd5) begin
        idx_d     = 3'd0;
        rev_cnt_d = rev_cnt_q + 16'd1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
    hall_d = hall_code(idx_d);

    acc_sum   = WIDE_W'(omega_q) + WIDE_W'(duty >> ACC_SHIFT);
    brake_dec = WIDE_W'(omega_q >> BRAKE_SHIFT) + WIDE_W'(1);
    omega_d   = omega_q;
    if (tick) begin
      case (drive_cls)
        CLS_MATCH: omega_d = (acc_sum > OMAX_WIDE) ? OMEGA_W'(OMEGA_MAX) : acc_sum[OMEGA_W-1:0];
        CLS_BRAKE: omega_d = (WIDE_W'(omega_q) > brake_dec) ? omega_q - brake_dec[OMEGA_W-1:0] : '0;
        default:   omega_d = omega_q - (omega_q >> FRIC_SHIFT);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= 3'd0;
      hall_q     <= 3'b101;
      omega_q    <= '0;
      pos_q      <= '0;
      tick_cnt_q <= '0;
      step_q     <= 1'b0;
      rev_cnt_q  <= 16'd0;
    end else begin
      idx_q      <= idx_d;
      hall_q     <= hall_d;
      omega_q    <= omega_d;
      pos_q      <= pos_d;
      tick_cnt_q <= tick_cnt_d;
      step_q     <= step_d;
      rev_cnt_q  <= rev_cnt_d;
    end
  end

  assign {hallGrn, hallYlw, hallBlu} = hall_q;
  assign omega   = omega_q;
  assign step    = step_q;
  assign rev_cnt = rev_cnt_q;

endmodule

// File: tb/tb_hall_emulator.sv
// Self-checking bench for hall_emulator: directed speed/brake/coast scenarios plus randomized
// drive, all compared every cycle against an arithmetic motor model.
module tb_hall_emulator;

  localparam int UPD  = 4;
  localparam int TH   = 1000;
  localparam int OMAX = 900;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel_grn = 2'b00;
  logic [1:0]  sel_ylw = 2'b00;
  logic [1:0]  sel_blu = 2'b00;
  logic [10:0] duty = 11'd0;
  logic        hall_grn, hall_ylw, hall_blu;
  logic [15:0] omega;
  logic        step;
  logic [15:0] rev_cnt;

  int checks   = 0;
  int failures = 0;

  // Rotor state -> drive pattern {G,Y,B} and hall code {G,Y,B}
  int PAT[6]  = '{36, 33, 9, 24, 18, 6};
  int HALL[6] = '{5, 4, 6, 2, 3, 1};

  int m_idx, m_omega, m_pos, m_cnt, m_rev, m_step;

  hall_emulator #(
    .UPD_DIV(UPD),
    .STEP_THRESH(TH),
    .OMEGA_MAX(OMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .selGrn(sel_grn),
    .selYlw(sel_ylw),
    .selBlu(sel_blu),
    .duty(duty),
    .hallGrn(hall_grn),
    .hallYlw(hall_ylw),
    .hallBlu(hall_blu),
    .omega(omega),
    .step(step),
    .rev_cnt(rev_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock of the motor, from the rules: class by old state, position with old speed
  task automatic modelStep();
    int sel, s, old_idx, old_omega, dec;
    bit tick;
    if (rst) begin
      m_idx = 0; m_omega = 0; m_pos = 0; m_cnt = 0; m_rev = 0; m_step = 0;
      return;
    end
    sel       = int'({sel_grn, sel_ylw, sel_blu});
    old_idx   = m_idx;
    old_omega = m_omega;
    tick      = (m_cnt == UPD - 1);
    m_cnt     = (m_cnt + 1) % UPD;
    s = m_pos + old_omega;
    if (s >= TH) begin
      m_pos  = s - TH;
      m_idx  = (old_idx + 1) % 6;
      m_step = 1;
      if (old_idx == 5) m_rev = (m_rev + 1) % 65536;
    end else begin
      m_pos  = s;
      m_step = 0;
    end
    if (tick) begin
      if (sel == 63) begin
        dec = old_omega / 16 + 1;
        m_omega = (old_omega > dec) ? old_omega - dec : 0;
      end else if (sel == PAT[old_idx]) begin
        m_omega = old_omega + int'(duty) / 16;
        if (m_omega > OMAX) m_omega = OMAX;
      end else begin
        m_omega = old_omega - old_omega / 256;
      end
    end
  endtask

  function automatic logic [5:0] goodSels();
    return 6'(PAT[m_idx]);
  endfunction

  function automatic logic [5:0] wrongSels();
    return 6'(PAT[(m_idx + 2) % 6]);
  endfunction

  task automatic applyStimulus(input logic r, input logic [5:0] sels, input logic [10:0] d);
    rst = r;
    {sel_grn, sel_ylw, sel_blu} = sels;
    duty = d;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("hall", int'({hall_grn, hall_ylw, hall_blu}), HALL[m_idx]);
    checkOutput("omega", int'(omega), m_omega);
    checkOutput("step", int'(step), m_step);
    checkOutput("rev_cnt", int'(rev_cnt), m_rev);
  endtask

  initial begin
    logic [5:0]  rs;
    logic [10:0] rd;
    int          pick;

    repeat (2) applyStimulus(1'b1, 6'd0, 11'd0);
    checkOutput("rst_hall", int'({hall_grn, hall_ylw, hall_blu}), 5);
    checkOutput("rst_omega", int'(omega), 0);
    checkOutput("rst_rev", int'(rev_cnt), 0);
    checkOutput("rst_step", int'(step), 0);

    repeat (100) applyStimulus(1'b0, 6'd0, 11'h400);
    checkOutput("idle_hall", int'({hall_grn, hall_ylw, hall_blu}), 5);
    checkOutput("idle_omega", int'(omega), 0);

    // Acceleration under correct commutation: +64 per tick, saturating at 900
    applyStimulus(1'b1, 6'd0, 11'd0);
    repeat (20) applyStimulus(1'b0, goodSels(), 11'h400);
    checkOutput("accel_5ticks", int'(omega), 320);
    repeat (36) applyStimulus(1'b0, goodSels(), 11'h400);
    checkOutput("accel_14ticks", int'(omega), 896);
    repeat (4) applyStimulus(1'b0, goodSels(), 11'h400);
    checkOutput("accel_sat", int'(omega), 900);
    repeat (8) applyStimulus(1'b0, goodSels(), 11'h400);
    checkOutput("sat_hold", int'(omega), 900);

    repeat (4) applyStimulus(1'b0, 6'b111111, 11'h400);
    checkOutput("brake_1tick", int'(omega), 843);
    repeat (800) applyStimulus(1'b0, 6'b111111, 11'h400);
    checkOutput("brake_floor", int'(omega), 0);

    // Closed loop at full duty, then wrong-phase drive coasts down by >>8 per tick
    applyStimulus(1'b1, 6'd0, 11'd0);
    repeat (200) applyStimulus(1'b0, goodSels(), 11'h7FF);
    checkOutput("loop_sat", int'(omega), 900);
    checkOutput("loop_revs", int'(rev_cnt != 16'd0), 1);
    repeat (40) applyStimulus(1'b0, wrongSels(), 11'h7FF);
    checkOutput("coast_10ticks", int'(omega), 870);

    repeat (2000) begin
      pick = int'($urandom_range(0, 9));
      rd   = 11'($urandom_range(0, 2047));
      if (pick <= 5)      rs = goodSels();
      else if (pick <= 7) rs = 6'b111111;
      else if (pick == 8) rs = 6'($urandom);
      else                rs = 6'd0;
      applyStimulus(1'b0, rs, rd);
    end

    repeat (60) applyStimulus(1'b0, goodSels(), 11'h7FF);
    applyStimulus(1'b1, goodSels(), 11'h7FF);
    checkOutput("midrst_hall", int'({hall_grn, hall_ylw, hall_blu}), 5);
    checkOutput("midrst_omega", int'(omega), 0);
    checkOutput("midrst_rev", int'(rev_cnt), 0);
    checkOutput("midrst_step", int'(step), 0);
    repeat (20) applyStimulus(1'b0, goodSels(), 11'h7FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
